lii_egress_packetizer: RTL and testbench
========================================

// Module: lii_egress_packetizer
// PURPOSE
//  Sits directly downstream of a kernel wrapper's LII phy output (e.g. conv5 lii_out_p0) and feeds the LII fabric.
//  Buffers kernel output beats, restamps src/dst with fixed node IDs and emits gap-free bursts of BURST beats with tlast.
//  A flush request drains a partial burst at end of layer. Decouples kernel clock-enable from fabric back-pressure.
// PARAMETERS
//  PW      128    data/packing width in bits
//  DEPTH   16     FIFO entries; power of two, DEPTH >= BURST
//  BURST   8      beats per burst; 1..DEPTH
//  SRC_ID  8'd5   node ID driven on m_src
//  DST_ID  8'd6   node ID driven on m_dst
// PORTS
//  aclk         in   1      clock, all logic rising-edge
//  arst         in   1      reset, synchronous, active-high
//  s_tdata      in   PW     upstream beat (from wrapper lii_out_p0_tdata)
//  s_tvalid     in   1      upstream valid
//  s_tready     out  1      upstream ready
//  flush        in   1      one-cycle pulse: emit buffered remainder as a short burst
//  m_tdata      out  PW     fabric beat
//  m_tvalid     out  1      fabric valid
//  m_tready     in   1      fabric ready
//  m_tlast      out  1      last beat of burst
//  m_src        out  8      constant SRC_ID
//  m_dst        out  8      constant DST_ID
//  occupancy    out  $clog2(DEPTH)+1  FIFO fill level
//  bursts_sent  out  16     burst counter, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  Reset (arst=1 at edge): FIFO empty, occupancy=0, state IDLE, beat_cnt=0, flush_pend=0, bursts_sent=0;
//   s_tready=0, m_tvalid=0, m_tlast=0 while arst high; s_tready=1 the cycle after arst falls. Reset mid-burst drops all data.
//  Input: push when s_tvalid & s_tready; s_tready = !full (registered occupancy, no same-cycle pop bypass).
//  FIFO: first-word-fall-through; m_tdata = head entry combinationally from storage.
//  Handshake: once m_tvalid=1 it holds with m_tdata/m_tlast stable until m_tready; pop on m_tvalid & m_tready.
//  Simultaneous push+pop: occupancy unchanged; pointers wrap mod DEPTH.
//  flush_pend: set on flush pulse, cleared when a burst carrying the remainder starts, or when flush seen with occupancy=0 in IDLE (no-op).
//  FSM:
//   IDLE : m_tvalid=0. If occupancy >= BURST -> SEND, burst_len=BURST.
//          Else if flush_pend & occupancy>0 -> SEND, burst_len=occupancy (1..BURST-1), clear flush_pend.
//          Decision uses registered occupancy; first beat valid the cycle after condition true.
//   SEND : m_tvalid=1 every cycle (all burst beats already resident, no bubbles).
//          beat_cnt increments on each pop; m_tlast = (beat_cnt == burst_len-1).
//          Pop with m_tlast -> IDLE, beat_cnt=0, bursts_sent+1. Back-to-back bursts have one idle cycle between.
//  flush arriving during SEND stays pending and is evaluated in next IDLE; push continues during SEND.
//  Flush while occupancy >= BURST: full bursts drain first; remainder (if any) sent as short burst afterwards.
//  m_src/m_dst constant, independent of reset. burst_len width $clog2(BURST)+1.
// STRUCTURE
//  Shared package lii_pkg: LII_PW default, node ID localparams (CONV5_ID etc.), node-ID typedef (8 bit).
//  Sub-module lii_sync_fifo (FWFT, PW x DEPTH, count output); FSM, counters, flush latch in this module.
// TESTING
//  1 Reset: hold arst 3 cycles with s_tvalid=1 -> s_tready=0, m_tvalid=0, occupancy=0; s_tready=1 cycle after release.
//  2 Push 8 beats 0..7, m_tready=1 -> 8 consecutive beats data 0..7, m_tlast only on 7, m_src=5/m_dst=6, bursts_sent=1.
//  3 Push 3 beats, no flush -> m_tvalid stays 0 for 50 cycles; pulse flush -> 3-beat burst, tlast on 3rd, flush_pend cleared.
//  4 m_tready=0, push 20 beats -> s_tready=0 at occupancy=16, no data loss; release -> two 8-beat bursts in order, 4 stay buffered.
//  5 Random m_tready (50%) mid-burst -> m_tdata/m_tlast stable while stalled, order preserved across 1000 beats vs scoreboard.
//  6 Flush during SEND with 2 extra beats queued; also flush with empty FIFO -> short 2-beat burst follows; empty flush emits nothing.

Source files
------------

// File: rtl/lii_pkg.sv
// ---------------------------------------------------------------------------
// lii_pkg
//   Shared definitions for LII fabric blocks: default packing width, the
//   8-bit node-ID type, the node IDs of the kernels wired to the fabric and
//   the egress packetizer state encoding.
// ---------------------------------------------------------------------------
package lii_pkg;

    localparam int LII_PW = 128;

    typedef logic [7:0] node_id_t;

    localparam node_id_t CONV4_ID = 8'd4;
    localparam node_id_t CONV5_ID = 8'd5;
    localparam node_id_t CONV6_ID = 8'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/lii_sync_fifo.sv
// ---------------------------------------------------------------------------
// lii_sync_fifo
//   Single-clock first-word-fall-through FIFO, PW bits x DEPTH entries.
//   The head entry is presented combinationally on rd_data whenever the FIFO
//   is non-empty, so a consumer can pop it in the same cycle it sees it.
// Ports
//   clk      in   1                 clock, rising edge
//   srst     in   1                 synchronous active-high reset (pointers, count)
//   wr_data  in   PW                data to write
//   wr_en    in   1                 write request (ignored when full)
//   rd_en    in   1                 pop request (ignored when empty)
//   rd_data  out  PW                head entry
//   full     out  1                 count == DEPTH
//   count    out  $clog2(DEPTH)+1   fill level
// ---------------------------------------------------------------------------
module lii_sync_fifo
    import lii_pkg::*;
#(
    parameter int PW    = LII_PW,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [PW-1:0]            wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [PW-1:0]            rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          do_wr;
    logic          do_rd;
    logic          empty;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_comb begin
        count_next = count_reg;
        case ({do_wr, do_rd})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset: stale contents are unreachable once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/lii_egress_packetizer.sv
// ---------------------------------------------------------------------------
// lii_egress_packetizer
//   Buffers kernel output beats and emits them onto the LII fabric as
//   gap-free bursts of BURST beats (tlast on the final beat), stamped with
//   fixed source/destination node IDs. A flush pulse drains a partial burst
//   at end of layer. A burst is only started once all of its beats are
//   resident, so m_tvalid never drops mid-burst.
// Ports
//   aclk, arst          clock / synchronous active-high reset
//   s_tdata/tvalid/tready  upstream beat stream from the kernel wrapper
//   flush               one-cycle pulse: send buffered remainder as short burst
//   m_tdata/tvalid/tready/tlast  fabric beat stream
//   m_src, m_dst        constant SRC_ID / DST_ID
//   occupancy           FIFO fill level
//   bursts_sent         completed-burst counter, wraps
// ---------------------------------------------------------------------------
module lii_egress_packetizer
    import lii_pkg::*;
#(
    parameter int       PW     = LII_PW,
    parameter int       DEPTH  = 16,
    parameter int       BURST  = 8,
    parameter node_id_t SRC_ID = CONV5_ID,
    parameter node_id_t DST_ID = CONV6_ID
) (
    input  logic                     aclk,
    input  logic                     arst,
    input  logic [PW-1:0]            s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic                     flush,
    output logic [PW-1:0]            m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output node_id_t                 m_src,
    output node_id_t                 m_dst,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [15:0]              bursts_sent
);

    localparam int OW = $clog2(DEPTH) + 1;
    localparam int LW = $clog2(BURST) + 1;
    localparam logic [OW-1:0] BURST_OCC = OW'(BURST);
    localparam logic [LW-1:0] BURST_LEN = LW'(BURST);

    pkt_state_t    state_reg, state_next;
    logic [LW-1:0] beat_cnt_reg, beat_cnt_next;
    logic [LW-1:0] burst_len_reg, burst_len_next;
    logic          flush_pend_reg, flush_pend_next;
    logic [15:0]   bursts_reg, bursts_next;
    logic          ready_en_reg;   // holds s_tready low until the cycle after reset
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign s_tready = ready_en_reg & ~fifo_full;
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    lii_sync_fifo #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .srst    (arst),
        .wr_data (s_tdata),
        .wr_en   (push),
        .rd_en   (pop),
        .rd_data (m_tdata),
        .full    (fifo_full),
        .count   (occupancy)
    );

    // State register and counters
    always_ff @(posedge aclk) begin
        if (arst) begin
            state_reg      <= ST_IDLE;
            beat_cnt_reg   <= '0;
            burst_len_reg  <= BURST_LEN;
            flush_pend_reg <= 1'b0;
            bursts_reg     <= '0;
            ready_en_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            burst_len_reg  <= burst_len_next;
            flush_pend_reg <= flush_pend_next;
            bursts_reg     <= bursts_next;
            ready_en_reg   <= 1'b1;
        end
    end

    // Next-state logic. Burst start decisions look only at the registered
    // occupancy, so the first beat is valid the cycle after the decision.
    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        burst_len_next  = burst_len_reg;
        flush_pend_next = flush_pend_reg;
        bursts_next     = bursts_reg;
        case (state_reg)
            ST_IDLE: begin
                if (occupancy >= BURST_OCC) begin
                    // Full bursts go first; a pending flush waits for the remainder.
                    state_next     = ST_SEND;
                    burst_len_next = BURST_LEN;
                    beat_cnt_next  = '0;
                end else if (flush_pend_reg && (occupancy != '0)) begin
                    state_next      = ST_SEND;
                    burst_len_next  = LW'(occupancy);
                    beat_cnt_next   = '0;
                    flush_pend_next = 1'b0;
                end else if (flush_pend_reg) begin
                    // Nothing buffered: the flush is a no-op.
                    flush_pend_next = 1'b0;
                end
            end
            ST_SEND: begin
                if (pop) begin
                    if (m_tlast) begin
                        state_next    = ST_IDLE;
                        beat_cnt_next = '0;
                        bursts_next   = bursts_reg + 16'd1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A new pulse always wins so it is never lost to a same-cycle clear.
        if (flush) begin
            flush_pend_next = 1'b1;
        end
    end

    // Outputs
    always_comb begin
        m_tvalid = (state_reg == ST_SEND);
        m_tlast  = (state_reg == ST_SEND) && (beat_cnt_reg == (burst_len_reg - 1'b1));
    end

    assign m_src       = SRC_ID;
    assign m_dst       = DST_ID;
    assign bursts_sent = bursts_reg;

endmodule

// File: tb/tb_lii_egress_packetizer.sv
// ---------------------------------------------------------------------------
// tb_lii_egress_packetizer
//   Scoreboard bench: every accepted upstream beat is queued, every fabric
//   handshake pops the queue and is compared. Burst boundaries (tlast) and
//   the burst count are predicted by each scenario from its own stimulus.
// ---------------------------------------------------------------------------
module tb_lii_egress_packetizer;

    localparam int PW    = 128;
    localparam int DEPTH = 16;
    localparam int BURST = 8;

    logic          aclk = 1'b0;
    logic          arst = 1'b1;
    logic [PW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          flush = 1'b0;
    logic [PW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [7:0]    m_src;
    logic [7:0]    m_dst;
    logic [4:0]    occupancy;
    logic [15:0]   bursts_sent;

    int            n_cmp = 0;
    int            n_err = 0;
    int            exp_bursts = 0;
    int            tx_seq = 0;
    bit            use_rand = 1'b0;
    logic [PW-1:0] exp_q[$];

    always #5 aclk = ~aclk;

    lii_egress_packetizer #(
        .PW     (PW),
        .DEPTH  (DEPTH),
        .BURST  (BURST),
        .SRC_ID (8'd5),
        .DST_ID (8'd6)
    ) dut (
        .aclk        (aclk),
        .arst        (arst),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .flush       (flush),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tlast     (m_tlast),
        .m_src       (m_src),
        .m_dst       (m_dst),
        .occupancy   (occupancy),
        .bursts_sent (bursts_sent)
    );

    // One clock cycle: drive inputs at the falling edge, sample 1 ns later,
    // record the handshakes that the next rising edge will perform.
    task automatic step(input bit sv, input bit mr, input bit fl,
                        output bit pu, output bit po, output bit gv,
                        output logic [PW-1:0] gd, output bit gl,
                        output logic [PW-1:0] ed);
        logic [PW-1:0] d;
        d = use_rand ? {$urandom(), $urandom(), $urandom(), 32'(tx_seq)} : PW'(tx_seq);
        s_tvalid = sv;
        s_tdata  = d;
        m_tready = mr;
        flush    = fl;
        #1;
        pu = sv && (s_tready === 1'b1);
        gv = (m_tvalid === 1'b1);
        po = gv && mr;
        gd = m_tdata;
        gl = (m_tlast === 1'b1);
        ed = 'x;
        if (pu) begin
            exp_q.push_back(d);
            tx_seq++;
        end
        if (po && exp_q.size() > 0) ed = exp_q.pop_front();
        @(negedge aclk);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        s_tvalid = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        n_cmp++; if (s_tready !== 1'b0) begin n_err++; $display("FAIL rst_s_tready got %b want 0", s_tready); end
        n_cmp++; if (m_tvalid !== 1'b0) begin n_err++; $display("FAIL rst_m_tvalid got %b want 0", m_tvalid); end
        n_cmp++; if (m_tlast !== 1'b0) begin n_err++; $display("FAIL rst_m_tlast got %b want 0", m_tlast); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rst_occupancy got %0d want 0", occupancy); end
        n_cmp++; if (bursts_sent !== 16'd0) begin n_err++; $display("FAIL rst_bursts got %0d want 0", bursts_sent); end
        arst = 1'b0;
        s_tvalid = 1'b0;
        @(negedge aclk);
        #1;
        n_cmp++; if (s_tready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b want 1", s_tready); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL rst_release_occ got %0d want 0", occupancy); end
        n_cmp++; if (m_src !== 8'd5 || m_dst !== 8'd6) begin n_err++; $display("FAIL rst_ids got %0d/%0d want 5/6", m_src, m_dst); end
        @(negedge aclk);
        $display("test_reset done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_full_burst();
        bit pu, po, gv, gl;
        logic [PW-1:0] gd, ed;
        int pushes = 0, pops = 0;
        tx_seq = 0;
        for (int cyc = 0; cyc < 100 && pops < 8; cyc++) begin
            step(pushes < 8, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
            if (pops > 0) begin
                n_cmp++; if (!po) begin n_err++; $display("FAIL t2_bubble after beat %0d got valid=%b want 1", pops, gv); end
            end
            if (po) begin
                n_cmp++; if (gd !== PW'(pops) || gd !== ed) begin n_err++; $display("FAIL t2_data beat %0d got %h want %h", pops, gd, ed); end
                n_cmp++; if (gl !== (pops == 7)) begin n_err++; $display("FAIL t2_tlast beat %0d got %b want %b", pops, gl, pops == 7); end
                n_cmp++; if (m_src !== 8'd5 || m_dst !== 8'd6) begin n_err++; $display("FAIL t2_ids got %0d/%0d want 5/6", m_src, m_dst); end
                pops++;
            end
        end
        n_cmp++; if (pops != 8) begin n_err++; $display("FAIL t2_timeout got %0d beats want 8", pops); end
        exp_bursts += 1;
        step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
        n_cmp++; if (bursts_sent !== 16'(exp_bursts)) begin n_err++; $display("FAIL t2_bursts got %0d want %0d", bursts_sent, exp_bursts); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL t2_occ got %0d want 0", occupancy); end
        $display("test_full_burst done: beats=%0d compared=%0d mismatched=%0d", pops, n_cmp, n_err);
    endtask

    task automatic test_flush_short();
        bit pu, po, gv, gl;
        logic [PW-1:0] gd, ed;
        int pushes = 0, pops = 0;
        for (int cyc = 0; cyc < 53; cyc++) begin
            step(pushes < 3, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
            n_cmp++; if (gv) begin n_err++; $display("FAIL t3_noflush_valid cycle %0d got 1 want 0", cyc); end
        end
        step(1'b0, 1'b1, 1'b1, pu, po, gv, gd, gl, ed);
        for (int cyc = 0; cyc < 20 && pops < 3; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (po) begin
                n_cmp++; if (gd !== ed) begin n_err++; $display("FAIL t3_data beat %0d got %h want %h", pops, gd, ed); end
                n_cmp++; if (gl !== (pops == 2)) begin n_err++; $display("FAIL t3_tlast beat %0d got %b want %b", pops, gl, pops == 2); end
                pops++;
            end
        end
        n_cmp++; if (pops != 3) begin n_err++; $display("FAIL t3_timeout got %0d beats want 3", pops); end
        exp_bursts += 1;
        // A stale pending flush would send this lone beat on its own.
        pushes = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step(pushes < 1, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
            n_cmp++; if (gv) begin n_err++; $display("FAIL t3_pend_cleared cycle %0d got valid 1 want 0", cyc); end
        end
        step(1'b0, 1'b1, 1'b1, pu, po, gv, gd, gl, ed);
        pops = 0;
        for (int cyc = 0; cyc < 20 && pops < 1; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (po) begin
                n_cmp++; if (gd !== ed || gl !== 1'b1) begin n_err++; $display("FAIL t3_single got %h/%b want %h/1", gd, gl, ed); end
                pops++;
            end
        end
        n_cmp++; if (pops != 1) begin n_err++; $display("FAIL t3_single_timeout got %0d want 1", pops); end
        exp_bursts += 1;
        step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
        n_cmp++; if (bursts_sent !== 16'(exp_bursts)) begin n_err++; $display("FAIL t3_bursts got %0d want %0d", bursts_sent, exp_bursts); end
        $display("test_flush_short done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_backpressure();
        bit pu, po, gv, gl;
        logic [PW-1:0] gd, ed;
        int pushes = 0, pops = 0;
        for (int cyc = 0; cyc < 40 && pushes < 16; cyc++) begin
            step(1'b1, 1'b0, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
        end
        n_cmp++; if (pushes != 16) begin n_err++; $display("FAIL t4_fill got %0d pushes want 16", pushes); end
        for (int cyc = 0; cyc < 4; cyc++) begin
            step(1'b1, 1'b0, 1'b0, pu, po, gv, gd, gl, ed);
            n_cmp++; if (pu) begin n_err++; $display("FAIL t4_full_accept cycle %0d got push want none", cyc); end
            n_cmp++; if (occupancy !== 5'd16 || s_tready !== 1'b0) begin n_err++; $display("FAIL t4_full got occ=%0d ready=%b want 16/0", occupancy, s_tready); end
        end
        for (int cyc = 0; cyc < 100 && pops < 16; cyc++) begin
            step(pushes < 20, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
            if (po) begin
                n_cmp++; if (gd !== ed) begin n_err++; $display("FAIL t4_data beat %0d got %h want %h", pops, gd, ed); end
                n_cmp++; if (gl !== (pops % 8 == 7)) begin n_err++; $display("FAIL t4_tlast beat %0d got %b want %b", pops, gl, pops % 8 == 7); end
                pops++;
            end
        end
        n_cmp++; if (pops != 16 || pushes != 20) begin n_err++; $display("FAIL t4_timeout got pops=%0d pushes=%0d want 16/20", pops, pushes); end
        exp_bursts += 2;
        for (int cyc = 0; cyc < 20; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            n_cmp++; if (gv) begin n_err++; $display("FAIL t4_leftover_valid cycle %0d got 1 want 0", cyc); end
        end
        n_cmp++; if (occupancy !== 5'd4) begin n_err++; $display("FAIL t4_leftover_occ got %0d want 4", occupancy); end
        step(1'b0, 1'b1, 1'b1, pu, po, gv, gd, gl, ed);
        pops = 0;
        for (int cyc = 0; cyc < 20 && pops < 4; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (po) begin
                n_cmp++; if (gd !== ed || gl !== (pops == 3)) begin n_err++; $display("FAIL t4_drain beat %0d got %h/%b want %h/%b", pops, gd, gl, ed, pops == 3); end
                pops++;
            end
        end
        n_cmp++; if (pops != 4) begin n_err++; $display("FAIL t4_drain_timeout got %0d want 4", pops); end
        exp_bursts += 1;
        step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
        n_cmp++; if (bursts_sent !== 16'(exp_bursts)) begin n_err++; $display("FAIL t4_bursts got %0d want %0d", bursts_sent, exp_bursts); end
        $display("test_backpressure done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    task automatic test_random_stall();
        bit pu, po, gv, gl, mr, sv;
        bit prev_stall = 1'b0, prev_l = 1'b0;
        logic [PW-1:0] gd, ed, prev_d;
        int pushes = 0, pops = 0;
        prev_d = '0;
        use_rand = 1'b1;
        for (int cyc = 0; cyc < 20000 && pops < 1000; cyc++) begin
            sv = (pushes < 1000) && ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 1) == 1);
            step(sv, mr, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
            if (prev_stall) begin
                n_cmp++; if (!gv || gd !== prev_d || gl !== prev_l) begin n_err++; $display("FAIL t5_stall_stable beat %0d got %b/%h/%b want 1/%h/%b", pops, gv, gd, gl, prev_d, prev_l); end
            end
            prev_stall = gv && !mr;
            prev_d = gd;
            prev_l = gl;
            if (po) begin
                n_cmp++; if (gd !== ed) begin n_err++; $display("FAIL t5_data beat %0d got %h want %h", pops, gd, ed); end
                n_cmp++; if (gl !== (pops % 8 == 7)) begin n_err++; $display("FAIL t5_tlast beat %0d got %b want %b", pops, gl, pops % 8 == 7); end
                pops++;
            end
        end
        use_rand = 1'b0;
        n_cmp++; if (pops != 1000) begin n_err++; $display("FAIL t5_timeout got %0d beats want 1000", pops); end
        exp_bursts += 125;
        step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
        n_cmp++; if (bursts_sent !== 16'(exp_bursts)) begin n_err++; $display("FAIL t5_bursts got %0d want %0d", bursts_sent, exp_bursts); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL t5_occ got %0d want 0", occupancy); end
        $display("test_random_stall done: beats=%0d compared=%0d mismatched=%0d", pops, n_cmp, n_err);
    endtask

    task automatic test_flush_during_send();
        bit pu, po, gv, gl;
        logic [PW-1:0] gd, ed;
        int pushes = 0, pops = 0;
        gv = 1'b0;
        for (int cyc = 0; cyc < 40 && !(pushes == 10 && gv); cyc++) begin
            step(pushes < 10, 1'b0, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
        end
        n_cmp++; if (!gv || pushes != 10) begin n_err++; $display("FAIL t6_in_send got valid=%b pushes=%0d want 1/10", gv, pushes); end
        step(1'b0, 1'b0, 1'b1, pu, po, gv, gd, gl, ed);
        for (int cyc = 0; cyc < 60 && pops < 10; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (po) begin
                n_cmp++; if (gd !== ed) begin n_err++; $display("FAIL t6_data beat %0d got %h want %h", pops, gd, ed); end
                n_cmp++; if (gl !== (pops == 7 || pops == 9)) begin n_err++; $display("FAIL t6_tlast beat %0d got %b want %b", pops, gl, pops == 7 || pops == 9); end
                pops++;
            end
        end
        n_cmp++; if (pops != 10) begin n_err++; $display("FAIL t6_timeout got %0d beats want 10", pops); end
        exp_bursts += 2;
        step(1'b0, 1'b1, 1'b1, pu, po, gv, gd, gl, ed);
        for (int cyc = 0; cyc < 30; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            n_cmp++; if (gv) begin n_err++; $display("FAIL t6_empty_flush cycle %0d got valid 1 want 0", cyc); end
        end
        n_cmp++; if (bursts_sent !== 16'(exp_bursts)) begin n_err++; $display("FAIL t6_bursts_a got %0d want %0d", bursts_sent, exp_bursts); end
        pushes = 0;
        pops = 0;
        for (int cyc = 0; cyc < 2; cyc++) begin
            step(1'b1, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (pu) pushes++;
        end
        step(1'b0, 1'b1, 1'b1, pu, po, gv, gd, gl, ed);
        for (int cyc = 0; cyc < 20 && pops < 2; cyc++) begin
            step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
            if (po) begin
                n_cmp++; if (gd !== ed || gl !== (pops == 1)) begin n_err++; $display("FAIL t6_short beat %0d got %h/%b want %h/%b", pops, gd, gl, ed, pops == 1); end
                pops++;
            end
        end
        n_cmp++; if (pops != 2 || pushes != 2) begin n_err++; $display("FAIL t6_short_timeout got pops=%0d pushes=%0d want 2/2", pops, pushes); end
        exp_bursts += 1;
        step(1'b0, 1'b1, 1'b0, pu, po, gv, gd, gl, ed);
        n_cmp++; if (bursts_sent !== 16'(exp_bursts)) begin n_err++; $display("FAIL t6_bursts_b got %0d want %0d", bursts_sent, exp_bursts); end
        n_cmp++; if (occupancy !== 5'd0) begin n_err++; $display("FAIL t6_occ got %0d want 0", occupancy); end
        $display("test_flush_during_send done: compared=%0d mismatched=%0d", n_cmp, n_err);
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_flush_short();
        test_backpressure();
        test_random_stall();
        test_flush_during_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
